mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential arbiter and sequencer that shares one unified, variable-latency memory port between the core's instruction-fetch and load/store requesters. It converts load/store size and address into byte enables and lane-aligned data, and stalls the single-cycle datapath while an access is outstanding. It sits between the core (PC/fetch logic, main control, data path) and the memory.

## Interface
- ADDR_W, 32, address width
- MAX_WAIT, 15, cycles to wait for mem_ack_i before aborting (timeout build only)

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request, held until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address, word aligned
- if_gnt_o  out  1  fetch accepted this cycle
- if_valid_o  out  1  one-cycle pulse, if_rdata_o valid
- if_rdata_o  out  32  instruction word
- d_req_i  in  1  data request, held until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_size_i  in  2  0 = byte, 1 = half, 2 = word
- d_addr_i  in  ADDR_W  data byte address
- d_wdata_i  in  32  store data, lane 0 aligned
- d_gnt_o  out  1  data accepted this cycle
- d_valid_o  out  1  one-cycle pulse, access complete
- d_rdata_o  out  32  load data shifted to lane 0, not extended
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_W  word address, bits [1:0] = 0
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-shifted store data
- mem_ack_i  in  1  memory completion, read data valid same cycle
- mem_rdata_i  in  32  memory read word
- stall_o  out  1  core must hold PC/state
- err_o  out  1  one-cycle pulse: misaligned access or timeout

## Operation
- States: IDLE, IF_BUSY, D_BUSY.
- IDLE: grant chosen combinationally; data wins unless both requests are high and the last grant was data (flag last_d), in which case fetch wins.
- Grant cycle: gnt_o high for the winner; address/we/be/wdata registered; next state IF_BUSY or D_BUSY.
- BUSY: mem_req_o high with registered attributes. On mem_ack_i: rdata captured, next state IDLE, matching valid_o pulses next cycle.
- Byte enables: byte → 4'b0001 << addr[1:0]; half → 4'b0011 << {addr[1],1'b0}; word → 4'b1111. mem_wdata_o = d_wdata_i << (8*addr[1:0]); d_rdata_o = mem_rdata_i >> (8*addr[1:0]).
- Misaligned (half with addr[0]=1, word with addr[1:0]≠0, size=3): d_gnt_o high, no memory access, state stays IDLE, next cycle d_valid_o and err_o pulse with d_rdata_o = 0.
- stall_o = (if_req_i & ~if_valid_o) | (d_req_i & ~d_valid_o).
- Reset (any time, including mid-access): state IDLE, last_d = 0, every output 0; an abandoned memory request is not completed.

## Timing
- Grant at cycle N → mem_req_o from N+1 → ack at cycle M ≥ N+1 → valid_o at M+1; minimum load latency 2 cycles.
- State returns to IDLE in the valid cycle, so a new grant is possible in that same cycle; peak throughput one access per 2 cycles.
- mem_req_o and attributes are stable until ack; mem_ack_i is ignored in IDLE.
- gnt_o is combinational on req_i in IDLE; valid_o, err_o and rdata are registered.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: a 4-bit-or-wider counter clears at grant and increments every BUSY cycle without ack; when it reaches MAX_WAIT, mem_req_o drops, state returns to IDLE, valid_o and err_o pulse next cycle with rdata = 0.
- Undefined: no counter; BUSY waits indefinitely, and err_o reports misalignment only.

## Test plan
- Load word at 0x100, ack after 3 BUSY cycles with mem_rdata_i = 0xDEADBEEF → mem_be_o = 4'hF, d_valid_o at grant+5, d_rdata_o = 0xDEADBEEF.
- Store byte 0xA5 to 0x203 → mem_addr_o = 0x200, mem_be_o = 4'b1000, mem_wdata_o[31:24] = 0xA5, mem_we_o = 1.
- if_req_i and d_req_i held high together for 4 accesses → grants in the order D, IF, D, IF; stall_o stays high until both are served.
- Load half at 0x101 → err_o pulse, mem_req_o never asserted, d_rdata_o = 0.
- With MEM_ARB_TIMEOUT_EN, MAX_WAIT = 15 and no ack → mem_req_o drops after 15 BUSY cycles, err_o and valid_o pulse; a subsequent request is granted normally.
- Assert rst_ni low during D_BUSY → mem_req_o, stall_o and valid outputs go 0 immediately; after release, a fetch at 0x0 completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory port between instruction
// fetch and load/store. Converts size/address into byte enables and
// lane-aligned data, and stalls the core while an access is outstanding.
// Build option: define MEM_ARB_TIMEOUT_EN to abort accesses that receive no
// acknowledge within MAX_WAIT busy cycles.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_valid_o,
   output logic [31:0]       if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [1:0]        d_size_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [31:0]       d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_valid_o,
   output logic [31:0]       d_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [31:0]       mem_rdata_i,
   output logic              stall_o,
   output logic              err_o
);
   typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

   state_t      state_q, state_d;
   logic        last_d_q;
   logic        grant_if, grant_d;
   logic        misaligned;
   logic        timeout;
   logic [3:0]  be_d;
   logic [1:0]  offset_q;
   logic        busy;

   assign busy      = (state_q != IDLE);
   assign mem_req_o = busy;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int WAIT_W = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
   logic [WAIT_W-1:0] wait_q;

   // Watchdog: counts busy cycles that pass without an acknowledge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                   wait_q <= '0;
      else if (grant_if || grant_d)  wait_q <= '0;
      else if (busy && !mem_ack_i)   wait_q <= wait_q + WAIT_W'(1);
   end
`endif

   // Decode access size into lane enables and flag misaligned accesses
   always_comb begin
      be_d       = 4'b0000;
      misaligned = 1'b0;
      case (d_size_i)
         2'd0: be_d = 4'b0001 << d_addr_i[1:0];
         2'd1: begin
            be_d       = 4'b0011 << {d_addr_i[1], 1'b0};
            misaligned = d_addr_i[0];
         end
         2'd2: begin
            be_d       = 4'b1111;
            misaligned = |d_addr_i[1:0];
         end
         default: misaligned = 1'b1;
      endcase
   end

   // Arbitration and next-state: data wins unless it also won last time
   always_comb begin
      state_d  = state_q;
      grant_if = 1'b0;
      grant_d  = 1'b0;
      timeout  = 1'b0;
      case (state_q)
         IDLE: begin
            if (d_req_i && !(if_req_i && last_d_q)) begin
               grant_d = 1'b1;
               if (!misaligned) state_d = D_BUSY;
            end else if (if_req_i) begin
               grant_if = 1'b1;
               state_d  = IF_BUSY;
            end
         end
         IF_BUSY, D_BUSY: begin
            if (mem_ack_i) begin
               state_d = IDLE;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
               timeout = 1'b1;
               state_d = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset gating keeps every output low while rst_ni is asserted
   assign if_gnt_o = rst_ni & grant_if;
   assign d_gnt_o  = rst_ni & grant_d;
   assign stall_o  = rst_ni & ((if_req_i & ~if_valid_o) | (d_req_i & ~d_valid_o));

   // State register and round-robin history
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant_d)       last_d_q <= 1'b1;
         else if (grant_if) last_d_q <= 1'b0;
      end
   end

   // Latch memory attributes at grant; they stay stable until completion
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= 4'b0000;
         mem_wdata_o <= '0;
         offset_q    <= 2'b00;
      end else if (grant_if) begin
         mem_we_o    <= 1'b0;
         mem_addr_o  <= if_addr_i & ~ADDR_W'(3);
         mem_be_o    <= 4'b1111;
         mem_wdata_o <= '0;
         offset_q    <= 2'b00;
      end else if (grant_d && !misaligned) begin
         mem_we_o    <= d_we_i;
         mem_addr_o  <= d_addr_i & ~ADDR_W'(3);
         mem_be_o    <= be_d;
         mem_wdata_o <= d_wdata_i << {d_addr_i[1:0], 3'b000};
         offset_q    <= d_addr_i[1:0];
      end
   end

   // Completion: capture read data and pulse valid/err one cycle later
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         if_valid_o <= 1'b0;
         d_valid_o  <= 1'b0;
         err_o      <= 1'b0;
         if_rdata_o <= '0;
         d_rdata_o  <= '0;
      end else begin
         if_valid_o <= 1'b0;
         d_valid_o  <= 1'b0;
         err_o      <= 1'b0;
         if (state_q == IF_BUSY && (mem_ack_i || timeout)) begin
            if_valid_o <= 1'b1;
            if_rdata_o <= timeout ? '0 : mem_rdata_i;
            err_o      <= timeout;
         end
         if (state_q == D_BUSY && (mem_ack_i || timeout)) begin
            d_valid_o <= 1'b1;
            d_rdata_o <= timeout ? '0 : (mem_rdata_i >> {offset_q, 3'b000});
            err_o     <= timeout;
         end
         if (grant_d && misaligned) begin
            d_valid_o <= 1'b1;
            d_rdata_o <= '0;
            err_o     <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: randomized fetch/load/store traffic plus directed
// cases, checked against a transaction-level model and a memory responder.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int ADDR_W   = 32;
   localparam int MAX_WAIT = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic        if_gnt_o, if_valid_o;
   logic [31:0] if_rdata_o;
   logic        d_req_i = 1'b0;
   logic        d_we_i = 1'b0;
   logic [1:0]  d_size_i = 2'd0;
   logic [31:0] d_addr_i = '0;
   logic [31:0] d_wdata_i = '0;
   logic        d_gnt_o, d_valid_o;
   logic [31:0] d_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        stall_o, err_o;

   mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_valid_o(d_valid_o), .d_rdata_o(d_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } mtx_t;
   typedef struct { logic err; logic [31:0] rdata; logic chk; } rsp_t;

   mtx_t        mq[$];
   rsp_t        ifq[$];
   rsp_t        dq[$];
   logic [31:0] ref_mem [256];
   logic [31:0] dev_mem [256];

   // Transaction-level reference: grant choice, outstanding access, expected pulses
   int          out_kind = 0;
   int          busy_cnt = 0;
   bit          exp_if_v = 0, exp_d_v = 0, exp_err = 0, last_d_m = 0;
   bit          gd, gi;
   int          msz, mnb, moff, mw;
   logic [31:0] ma, mwd;
   logic [3:0]  mbe;
   rsp_t        rr;
   mtx_t        mt;

   always @(negedge clk) begin
      if (!rst_n) begin
         out_kind = 0; busy_cnt = 0; last_d_m = 0;
         exp_if_v = 0; exp_d_v = 0; exp_err = 0;
         mq.delete(); ifq.delete(); dq.delete();
      end else begin
         check("if_valid", if_valid_o, exp_if_v);
         check("d_valid", d_valid_o, exp_d_v);
         check("err", err_o, exp_err);
         check("stall", stall_o, (if_req_i && !exp_if_v) || (d_req_i && !exp_d_v));
         exp_if_v = 0; exp_d_v = 0; exp_err = 0;
         if (out_kind != 0) begin
            check("mem_req_busy", mem_req_o, 1);
            check("if_gnt_busy", if_gnt_o, 0);
            check("d_gnt_busy", d_gnt_o, 0);
            busy_cnt++;
            if (mem_ack_i) begin
               if (out_kind == 1) exp_if_v = 1; else exp_d_v = 1;
               out_kind = 0;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (busy_cnt == MAX_WAIT) begin
               exp_err = 1;
               if (out_kind == 1) begin
                  exp_if_v = 1; rr = ifq.pop_back(); rr.err = 1; rr.rdata = 0; rr.chk = 1; ifq.push_back(rr);
               end else begin
                  exp_d_v = 1; rr = dq.pop_back(); rr.err = 1; rr.rdata = 0; rr.chk = 1; dq.push_back(rr);
               end
               out_kind = 0;
            end
`endif
         end else begin
            check("mem_req_idle", mem_req_o, 0);
            gd = d_req_i && !(if_req_i && last_d_m);
            gi = if_req_i && !gd;
            check("d_gnt", d_gnt_o, gd);
            check("if_gnt", if_gnt_o, gi);
            if (gd) begin
               last_d_m = 1;
               ma = d_addr_i; msz = int'(d_size_i); mnb = 1 << msz;
               if (msz == 3 || (ma % mnb) != 0) begin
                  exp_d_v = 1; exp_err = 1;
                  rr.err = 1; rr.rdata = 0; rr.chk = 1; dq.push_back(rr);
               end else begin
                  moff = ma % 4; mw = (ma / 4) % 256;
                  mbe  = 4'(((1 << mnb) - 1) << moff);
                  mwd  = d_wdata_i << (8 * moff);
                  mt.we = d_we_i; mt.addr = ma - moff; mt.be = mbe; mt.wdata = mwd;
                  mq.push_back(mt);
                  if (d_we_i) begin
                     for (int b = 0; b < 4; b++)
                        if (mbe[b]) ref_mem[mw][b*8 +: 8] = mwd[b*8 +: 8];
                     rr.err = 0; rr.rdata = 0; rr.chk = 0;
                  end else begin
                     rr.err = 0; rr.rdata = ref_mem[mw] >> (8 * moff); rr.chk = 1;
                  end
                  dq.push_back(rr);
                  out_kind = 2; busy_cnt = 0;
               end
            end else if (gi) begin
               last_d_m = 0;
               ma = if_addr_i; mw = (ma / 4) % 256;
               mt.we = 0; mt.addr = ma & 32'hFFFF_FFFC; mt.be = 4'hF; mt.wdata = 0;
               mq.push_back(mt);
               rr.err = 0; rr.rdata = ref_mem[mw]; rr.chk = 1; ifq.push_back(rr);
               out_kind = 1; busy_cnt = 0;
            end
         end
      end
   end

   // Scoreboard monitor: pops expected responses whenever the DUT signals valid
   rsp_t mr;
   always @(negedge clk) begin
      if (rst_n) begin
         if (if_valid_o) begin
            if (ifq.size() == 0) check("if_spurious_valid", if_valid_o, 0);
            else begin
               mr = ifq.pop_front();
               if (mr.chk) check("if_rdata", if_rdata_o, mr.rdata);
            end
         end
         if (d_valid_o) begin
            if (dq.size() == 0) check("d_spurious_valid", d_valid_o, 0);
            else begin
               mr = dq.pop_front();
               if (mr.chk) check("d_rdata", d_rdata_o, mr.rdata);
            end
         end
      end
   end

   // Memory responder: random latency, checks attributes every busy cycle
   bit   active = 0;
   int   wait_left = 0;
   int   force_lat = -1;
   bit   no_ack = 0;
   int   rw;
   mtx_t cur;
   initial begin
      forever begin
         @(posedge clk); #1;
         mem_ack_i = 0; mem_rdata_i = $urandom;
         if (!rst_n || !mem_req_o) active = 0;
         else begin
            if (!active) begin
               active = 1;
               wait_left = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
               if (mq.size() == 0) check("mem_unexpected_req", mem_req_o, 0);
               else cur = mq.pop_front();
            end
            check("mem_we", mem_we_o, cur.we);
            check("mem_addr", mem_addr_o, cur.addr);
            check("mem_be", mem_be_o, cur.be);
            if (cur.we) check("mem_wdata", mem_wdata_o, cur.wdata);
            if (!no_ack) begin
               if (wait_left == 0) begin
                  mem_ack_i = 1;
                  rw = (mem_addr_o / 4) % 256;
                  mem_rdata_i = dev_mem[rw];
                  if (mem_we_o)
                     for (int b = 0; b < 4; b++)
                        if (mem_be_o[b]) dev_mem[rw][b*8 +: 8] = mem_wdata_o[b*8 +: 8];
                  active = 0;
               end else wait_left--;
            end
         end
      end
   end

   task automatic do_if(input logic [31:0] a);
      int n = 0;
      if_req_i = 1; if_addr_i = a;
      forever begin
         @(negedge clk);
         if (if_gnt_o) break;
         n++;
         if (n > 300) begin check("if_gnt_timeout", if_gnt_o, 1); break; end
      end
      @(posedge clk); #1;
      if_req_i = 0; if_addr_i = $urandom;
   endtask

   task automatic do_d(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output int g);
      int n = 0;
      g = -1;
      d_req_i = 1; d_we_i = we; d_size_i = sz; d_addr_i = a; d_wdata_i = wd;
      forever begin
         @(negedge clk);
         if (d_gnt_o) begin g = cyc; break; end
         n++;
         if (n > 300) begin check("d_gnt_timeout", d_gnt_o, 1); break; end
      end
      @(posedge clk); #1;
      d_req_i = 0; d_wdata_i = $urandom;
   endtask

   task automatic wait_d_valid(output int c);
      int n = 0;
      c = -1;
      while (n < 60) begin
         @(negedge clk);
         if (d_valid_o) begin c = cyc; break; end
         n++;
      end
      if (c < 0) check("d_valid_timeout", d_valid_o, 1);
   endtask

   task automatic wait_if_valid();
      int n = 0;
      bit seen = 0;
      while (n < 60 && !seen) begin
         @(negedge clk);
         seen = if_valid_o;
         n++;
      end
      check("if_valid_seen", seen, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int g, c, ng, n;
      logic [3:0] seq;
      logic [31:0] v;
      for (int i = 0; i < 256; i++) begin
         v = $urandom; ref_mem[i] = v; dev_mem[i] = v;
      end
      ref_mem[64] = 32'hDEADBEEF; dev_mem[64] = 32'hDEADBEEF;

      // Reset: outputs low even with both requests raised
      repeat (3) @(posedge clk);
      #1;
      if_req_i = 1; d_req_i = 1; d_size_i = 2; d_addr_i = 32'h20;
      #1;
      check("rst_mem_req", mem_req_o, 0);
      check("rst_stall", stall_o, 0);
      check("rst_d_gnt", d_gnt_o, 0);
      check("rst_if_gnt", if_gnt_o, 0);
      check("rst_valid", {if_valid_o, d_valid_o, err_o}, 0);
      if_req_i = 0; d_req_i = 0;
      @(posedge clk); #1;
      rst_n = 1;

      // Both requesters held high for four accesses: D, IF, D, IF
      seq = 0; ng = 0; n = 0;
      if_addr_i = 32'h10; d_addr_i = 32'h20; d_size_i = 2; d_we_i = 0;
      if_req_i = 1; d_req_i = 1;
      while (ng < 4 && n < 200) begin
         @(negedge clk); n++;
         if (d_gnt_o || if_gnt_o) begin
            seq = {seq[2:0], d_gnt_o}; ng++;
            @(posedge clk); #1;
            if_addr_i = if_addr_i + 4; d_addr_i = d_addr_i + 4;
         end
      end
      if_req_i = 0; d_req_i = 0;
      check("grant_order", seq, 4'b1010);
      repeat (8) @(posedge clk);
      #1;

      // Load word at 0x100 with three non-ack busy cycles
      force_lat = 3;
      do_d(0, 2, 32'h100, 0, g);
      wait_d_valid(c);
      check("load_latency", c - g, 5);
      check("load_rdata", d_rdata_o, 32'hDEADBEEF);
      force_lat = -1;
      @(posedge clk); #1;

      // Store byte 0xA5 to 0x203
      do_d(1, 0, 32'h203, 32'hA5, g);
      check("st_mem_req", mem_req_o, 1);
      check("st_addr", mem_addr_o, 32'h200);
      check("st_be", mem_be_o, 4'b1000);
      check("st_lane3", mem_wdata_o[31:24], 8'hA5);
      check("st_we", mem_we_o, 1);
      repeat (6) @(posedge clk);
      #1;

      // Misaligned half load at 0x101
      do_d(0, 1, 32'h101, 0, g);
      check("mis_err", err_o, 1);
      check("mis_valid", d_valid_o, 1);
      check("mis_rdata", d_rdata_o, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("mis_no_mem_req", mem_req_o, 0);
      end
      @(posedge clk); #1;

      // Randomized concurrent traffic
      fork
         begin
            for (int i = 0; i < 80; i++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               do_if(32'($urandom_range(0, 255)) << 2);
            end
         end
         begin
            int gg;
            for (int j = 0; j < 80; j++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               do_d(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    32'($urandom_range(0, 1023)), $urandom, gg);
            end
         end
      join
      repeat (10) @(posedge clk);
      #1;

`ifdef MEM_ARB_TIMEOUT_EN
      // No acknowledge: watchdog aborts, then a normal access follows
      no_ack = 1;
      do_d(0, 2, 32'h40, 0, g);
      wait_d_valid(c);
      check("tmo_latency", c - g, MAX_WAIT + 1);
      check("tmo_err", err_o, 1);
      no_ack = 0;
      @(posedge clk); #1;
      do_d(0, 2, 32'h44, 0, g);
      wait_d_valid(c);
      check("post_tmo_err", err_o, 0);
      repeat (4) @(posedge clk);
      #1;
`endif

      // Reset during a data access, then a fetch at 0x0
      force_lat = 10;
      do_d(0, 2, 32'h80, 0, g);
      d_req_i = 1;
      #2;
      rst_n = 0;
      #1;
      check("mid_rst_mem_req", mem_req_o, 0);
      check("mid_rst_stall", stall_o, 0);
      check("mid_rst_valid", {if_valid_o, d_valid_o, err_o}, 0);
      check("mid_rst_gnt", {if_gnt_o, d_gnt_o}, 0);
      d_req_i = 0;
      @(posedge clk); #1;
      force_lat = -1;
      rst_n = 1;
      do_if(32'h0);
      wait_if_valid();
      repeat (6) @(posedge clk);
      #1;
      check("drain_if", ifq.size(), 0);
      check("drain_d", dq.size(), 0);
      check("drain_mem", mq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
